// File: rtl/mv_pkg.sv
// Shared widths and FSM state encoding for the matched-filter score accumulator.
package mv_pkg;

    localparam int POS_W   = 13;
    localparam int SCORE_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/mv_score_accum_if.sv
// Sample/score bus of mv_score_accum: master drives the sample stream, slave returns window scores.
interface mv_score_accum_if
    import mv_pkg::*;
#(
    parameter int DATA_W = 16
);

    logic               iStart;
    logic               iValid;
    logic [DATA_W-1:0]  iData;
    logic [DATA_W-1:0]  iCoef;
    logic               oRst_reg;
    logic               oValid;
    logic [SCORE_W-1:0] oData_out;
    logic [POS_W-1:0]   oPosition;
    logic               oBusy;
    logic               oFrame_done;

    modport master (
        output iStart, iValid, iData, iCoef,
        input  oRst_reg, oValid, oData_out, oPosition, oBusy, oFrame_done
    );

    modport slave (
        input  iStart, iValid, iData, iCoef,
        output oRst_reg, oValid, oData_out, oPosition, oBusy, oFrame_done
    );

endinterface

// File: rtl/mv_mac.sv
// Multiply-accumulate for one window; sum_o is the running sum including the current sample.
// Macro MV_SCORE_SAT_EN selects saturating accumulation instead of modulo-2^32 wrap.
module mv_mac
    import mv_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic               iClk,
    input  logic               iReset,
    input  logic               en_i,
    input  logic               first_i,
    input  logic [DATA_W-1:0]  data_i,
    input  logic [DATA_W-1:0]  coef_i,
    output logic [SCORE_W-1:0] sum_o
);

    logic [2*DATA_W-1:0] prod_full;
    logic [SCORE_W-1:0]  prod;
    logic [SCORE_W-1:0]  base;
    logic [SCORE_W-1:0]  acc_q;
    logic [SCORE_W-1:0]  acc_d;
`ifdef MV_SCORE_SAT_EN
    logic [SCORE_W:0]    wide;
`endif

    always_comb begin
        prod_full = data_i * coef_i;
        prod      = SCORE_W'(prod_full);
        // The first sample of a window loads rather than adds, so no explicit clear is needed.
        base      = first_i ? '0 : acc_q;
`ifdef MV_SCORE_SAT_EN
        wide      = {1'b0, base} + {1'b0, prod};
        sum_o     = wide[SCORE_W] ? '1 : wide[SCORE_W-1:0];
`else
        sum_o     = base + prod;
`endif
        acc_d     = en_i ? sum_o : acc_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iClk) begin
        if (iReset) acc_q <= '0;
        else        acc_q <= acc_d;
    end

endmodule

// File: rtl/mv_score_accum.sv
// Frame sequencer: counts samples per window and windows per frame, registers each window score.
// Accumulator arithmetic lives in mv_mac (saturating when MV_SCORE_SAT_EN is defined).
module mv_score_accum
    import mv_pkg::*;
#(
    parameter int WIN_LEN = 64,
    parameter int NUM_POS = 4800,
    parameter int DATA_W  = 16
) (
    input  logic        iClk,
    input  logic        iReset,
    mv_score_accum_if.slave bus
);

    localparam int                 CNT_W    = $clog2(WIN_LEN);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIN_LEN - 1);
    localparam logic [POS_W-1:0]   POS_LAST = POS_W'(NUM_POS - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [POS_W-1:0]   idx_q, idx_d;
    logic               rst_reg_q, rst_reg_d;
    logic               valid_q, valid_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               accept;
    logic               frame_end;
    logic [SCORE_W-1:0] mac_sum;

    mv_mac #(.DATA_W(DATA_W)) u_mac (
        .iClk    (iClk),
        .iReset  (iReset),
        .en_i    (accept),
        .first_i (cnt_q == '0),
        .data_i  (bus.iData),
        .coef_i  (bus.iCoef),
        .sum_o   (mac_sum)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_reg_d = 1'b0;
        valid_d   = 1'b0;
        score_d   = score_q;
        pos_d     = pos_q;
        // The cycle showing the last window's score closes the frame; no sample is taken then.
        frame_end = valid_q && (pos_q == POS_LAST);
        accept    = (state_q == ST_ACCUM) && bus.iValid && !frame_end;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.iStart) begin
                    state_d   = ST_ACCUM;
                    rst_reg_d = 1'b1;
                    cnt_d     = '0;
                    idx_d     = '0;
                end
            end
            ST_ACCUM: begin
                if (frame_end) begin
                    state_d = ST_DONE;
                end else if (accept) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        score_d = mac_sum;
                        pos_d   = idx_q;
                        if (idx_q != POS_LAST) idx_d = idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_reg_q <= 1'b0;
            valid_q   <= 1'b0;
            score_q   <= '0;
            pos_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_reg_q <= rst_reg_d;
            valid_q   <= valid_d;
            score_q   <= score_d;
            pos_q     <= pos_d;
        end
    end

    assign bus.oRst_reg    = rst_reg_q;
    assign bus.oValid      = valid_q;
    assign bus.oData_out   = score_q;
    assign bus.oPosition   = pos_q;
    assign bus.oBusy       = (state_q != ST_IDLE);
    assign bus.oFrame_done = (state_q == ST_DONE);

endmodule
